// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Shared constants and helpers for the four-digit seven-segment scan driver.
//   - Hex glyphs 0-F, logical active-high, bit order a=bit0 .. g=bit6.
//   - Segment bit positions within the 8-bit {dp,g,f,e,d,c,b,a} bus.
//   - Digit count and helpers that pick a nibble / compute leading-zero blanking.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam int VALUE_W    = 4 * NUM_DIGITS;

   // Segment bit positions in the output bus
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef logic [3:0]         nibble_t;
   typedef logic [6:0]         glyph_t;
   typedef logic [IDX_W-1:0]   digit_idx_t;
   typedef logic [VALUE_W-1:0] value_t;

   // Standard hex glyphs
   localparam glyph_t GLYPH_0 = 7'h3F;
   localparam glyph_t GLYPH_1 = 7'h06;
   localparam glyph_t GLYPH_2 = 7'h5B;
   localparam glyph_t GLYPH_3 = 7'h4F;
   localparam glyph_t GLYPH_4 = 7'h66;
   localparam glyph_t GLYPH_5 = 7'h6D;
   localparam glyph_t GLYPH_6 = 7'h7D;
   localparam glyph_t GLYPH_7 = 7'h07;
   localparam glyph_t GLYPH_8 = 7'h7F;
   localparam glyph_t GLYPH_9 = 7'h6F;
   localparam glyph_t GLYPH_A = 7'h77;
   localparam glyph_t GLYPH_B = 7'h7C;
   localparam glyph_t GLYPH_C = 7'h39;
   localparam glyph_t GLYPH_D = 7'h5E;
   localparam glyph_t GLYPH_E = 7'h79;
   localparam glyph_t GLYPH_F = 7'h71;
   localparam glyph_t GLYPH_OFF = 7'h00;

   // Nibble belonging to digit idx (digit 0 = value[3:0])
   function automatic nibble_t digit_nibble(input value_t value, input digit_idx_t idx);
      nibble_t n;
      n = 4'h0;
      case (idx)
         2'd0: n = value[3:0];
         2'd1: n = value[7:4];
         2'd2: n = value[11:8];
         2'd3: n = value[15:12];
         default: n = 4'h0;
      endcase
      return n;
   endfunction

   // Bit i set when digit i and every higher digit are zero. Bit 0 is always
   // clear because the least-significant digit is never blanked.
   function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input value_t value);
      logic [NUM_DIGITS-1:0] m;
      m    = '0;
      m[3] = (value[15:12] == 4'h0);
      m[2] = m[3] && (value[11:8] == 4'h0);
      m[1] = m[2] && (value[7:4] == 4'h0);
      m[0] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_mux_if
//   Bundles the display data inputs and the pin-side outputs of the scan driver.
//   There is no handshake: the data inputs are level signals sampled on every
//   clock, and the outputs are registered pin values.
//   master : the data source (board counters / bench) - drives en, value, dp,
//            blank_lz and observes the pins.
//   slave  : the scan driver - consumes the data and drives the pins.
//   Signals:
//     en           display enable; 0 blanks all anodes
//     value[15:0]  digit3..digit0 nibbles
//     dp[3:0]      decimal point request per digit
//     blank_lz     leading-zero blanking enable
//     sevenSegment {dp,g,f,e,d,c,b,a} at the pins
//     anode[3:0]   digit select at the pins
//     digit_idx    index of the digit currently driven
// -----------------------------------------------------------------------------
interface seven_seg_scan_mux_if;
   import seven_seg_pkg::*;

   logic                  en;
   logic [VALUE_W-1:0]    value;
   logic [NUM_DIGITS-1:0] dp;
   logic                  blank_lz;
   logic [7:0]            sevenSegment;
   logic [NUM_DIGITS-1:0] anode;
   logic [IDX_W-1:0]      digit_idx;

   modport master (
      output en, value, dp, blank_lz,
      input  sevenSegment, anode, digit_idx
   );

   modport slave (
      input  en, value, dp, blank_lz,
      output sevenSegment, anode, digit_idx
   );

endinterface

// File: rtl/seven_seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_hex_decode
//   Pure combinational nibble -> seven-segment glyph, logical active-high.
//   Pin polarity is not handled here; the top-level output stage owns it.
//   Ports:
//     nibble[3:0]  hex digit 0-F
//     glyph[6:0]   {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seven_seg_hex_decode
   import seven_seg_pkg::*;
(
   input  nibble_t nibble,
   output glyph_t  glyph
);

   always_comb begin
      glyph = GLYPH_OFF;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
         default: glyph = GLYPH_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_mux
//   Four-digit time-multiplexed seven-segment display driver. A refresh counter
//   divides clk into digit slots of REFRESH_COUNT cycles; each slot drives one
//   anode and the glyph of that digit on the shared segment bus. Supports
//   leading-zero blanking, per-digit decimal points and a global enable.
//   Parameters:
//     REFRESH_COUNT    clk cycles per digit slot (>= 2)
//     ANODE_ACTIVE_LOW 1 inverts the anode pins
//     SEG_ACTIVE_LOW   1 inverts all 8 segment pins
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   seven_seg_scan_mux_if.slave: en, value, dp, blank_lz in;
//           sevenSegment, anode, digit_idx out (all registered)
// -----------------------------------------------------------------------------
module seven_seg_scan_mux
   import seven_seg_pkg::*;
#(
   parameter int REFRESH_COUNT    = 50000,
   parameter bit ANODE_ACTIVE_LOW = 1'b0,
   parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   seven_seg_scan_mux_if.slave  bus
);

   localparam int CNT_W = $clog2(REFRESH_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_COUNT - 1);

   // Pin values for "everything off" after polarity is applied
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
   localparam logic [7:0]            SEG_OFF   = {8{SEG_ACTIVE_LOW}};

   // ---------------------------------------------------------------------------
   // Refresh counter and scan index. They free-run independently of en so the
   // digit schedule stays fixed while the display is disabled.
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   digit_idx_t       scan_idx_q;
   logic             slot_end;

   assign slot_end = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         scan_idx_q <= '0;
      end else begin
         if (slot_end) begin
            cnt_q      <= '0;
            scan_idx_q <= scan_idx_q + IDX_W'(1);
         end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Digit selection and decode for the current scan index
   // ---------------------------------------------------------------------------
   nibble_t               cur_nibble;
   glyph_t                cur_glyph;
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  cur_blank;
   logic [7:0]            seg_logical;
   logic [NUM_DIGITS-1:0] anode_logical;

   assign cur_nibble = digit_nibble(bus.value, scan_idx_q);
   assign lz_mask    = leading_zero_mask(bus.value);

   seven_seg_hex_decode u_decode (
      .nibble (cur_nibble),
      .glyph  (cur_glyph)
   );

   always_comb begin
      cur_blank     = bus.blank_lz && lz_mask[scan_idx_q];
      seg_logical   = 8'h00;
      // A blanked digit still shows its decimal point
      seg_logical[SEG_DP]          = bus.dp[scan_idx_q];
      seg_logical[SEG_G:SEG_A]     = cur_blank ? GLYPH_OFF : cur_glyph;
      anode_logical = '0;
      if (bus.en) begin
         anode_logical[scan_idx_q] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Output register: polarity is applied last, right before the pins. The
   // reset values are the inactive pin levels so nothing lights during reset.
   // ---------------------------------------------------------------------------
   logic [7:0]            seg_q;
   logic [NUM_DIGITS-1:0] anode_q;
   digit_idx_t            digit_idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q       <= SEG_OFF;
         anode_q     <= ANODE_OFF;
         digit_idx_q <= '0;
      end else begin
         seg_q       <= seg_logical ^ SEG_OFF;
         anode_q     <= anode_logical ^ ANODE_OFF;
         digit_idx_q <= scan_idx_q;
      end
   end

   assign bus.sevenSegment = seg_q;
   assign bus.anode        = anode_q;
   assign bus.digit_idx    = digit_idx_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan_mux
//   Two instances share the same inputs: dut_a (REFRESH_COUNT=4, active-high
//   pins) and dut_b (REFRESH_COUNT=3, both polarities inverted). A behavioural
//   model predicts every registered output from the number of clock edges since
//   reset and the inputs present at each edge.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_mux;

   localparam int RC_A = 4;
   localparam int RC_B = 3;

   // ---------------------------------------------------------------- clock/reset
   logic clk;
   logic rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- DUTs
   logic        en;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        blank_lz;

   seven_seg_scan_mux_if if_a ();
   seven_seg_scan_mux_if if_b ();

   assign if_a.en = en;
   assign if_a.value = value;
   assign if_a.dp = dp;
   assign if_a.blank_lz = blank_lz;
   assign if_b.en = en;
   assign if_b.value = value;
   assign if_b.dp = dp;
   assign if_b.blank_lz = blank_lz;

   seven_seg_scan_mux #(
      .REFRESH_COUNT    (RC_A),
      .ANODE_ACTIVE_LOW (1'b0),
      .SEG_ACTIVE_LOW   (1'b0)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   seven_seg_scan_mux #(
      .REFRESH_COUNT    (RC_B),
      .ANODE_ACTIVE_LOW (1'b1),
      .SEG_ACTIVE_LOW   (1'b1)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   // ---------------------------------------------------------------- bookkeeping
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Expected pins after an edge: {digit_idx[1:0], anode[3:0], seg[7:0]}.
   // k = number of non-reset edges already seen since the last reset edge.
   function automatic logic [13:0] model(input int rc, input bit al, input bit sl,
                                         input logic r, input int k, input logic e,
                                         input logic [15:0] v, input logic [3:0] d,
                                         input logic bl);
      logic [6:0] gt [16];
      logic [3:0] an;
      logic [7:0] sg;
      logic [3:0] nib;
      logic       blank;
      int         ix;
      gt = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      an = 4'h0;
      sg = 8'h00;
      ix = 0;
      if (!r) begin
         ix    = (k / rc) % 4;
         nib   = 4'((v >> (4 * ix)) & 16'h000F);
         blank = bl && (ix > 0) && ((v >> (4 * ix)) == 16'h0000);
         sg    = {d[ix], blank ? 7'h00 : gt[nib]};
         an    = e ? 4'(1 << ix) : 4'h0;
      end
      if (al) an = ~an;
      if (sl) sg = ~sg;
      return {2'(ix), an, sg};
   endfunction

   // ---------------------------------------------------------------- scoreboard
   logic [13:0] exp_q_a[$];
   logic [13:0] exp_q_b[$];
   bit          armed = 1'b0;
   int          k_edges = 0;

   always @(posedge clk) begin
      if (rst) armed = 1'b1;
      if (armed) begin
         exp_q_a.push_back(model(RC_A, 1'b0, 1'b0, rst, k_edges, en, value, dp, blank_lz));
         exp_q_b.push_back(model(RC_B, 1'b1, 1'b1, rst, k_edges, en, value, dp, blank_lz));
         k_edges = rst ? 0 : k_edges + 1;
      end
   end

   always @(negedge clk) begin
      logic [13:0] ea;
      logic [13:0] eb;
      if (exp_q_a.size() > 0 && exp_q_b.size() > 0) begin
         ea = exp_q_a.pop_front();
         eb = exp_q_b.pop_front();
         check("a_digit_idx", 32'(if_a.digit_idx), 32'(ea[13:12]));
         check("a_anode", 32'(if_a.anode), 32'(ea[11:8]));
         check("a_seg", 32'(if_a.sevenSegment), 32'(ea[7:0]));
         check("b_digit_idx", 32'(if_b.digit_idx), 32'(eb[13:12]));
         check("b_anode", 32'(if_b.anode), 32'(eb[11:8]));
         check("b_seg", 32'(if_b.sevenSegment), 32'(eb[7:0]));
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic set_inputs(input logic e, input logic [15:0] v, input logic [3:0] d,
                             input logic bl);
      en = e;
      value = v;
      dp = d;
      blank_lz = bl;
   endtask

   // One reset edge then release; returns at the negedge after the first
   // post-reset edge (digit 0 on the pins).
   task automatic restart();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_a(input string name, input logic [3:0] an, input logic [7:0] sg);
      check({name, "_anode"}, 32'(if_a.anode), 32'(an));
      check({name, "_seg"}, 32'(if_a.sevenSegment), 32'(sg));
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      rst = 1'b1;
      set_inputs(1'b1, 16'h1234, 4'b0000, 1'b0);
      repeat (3) @(negedge clk);

      // Reset pins
      check_a("rst_a", 4'b0000, 8'h00);
      check("rst_a_idx", 32'(if_a.digit_idx), 32'd0);
      check("rst_b_anode", 32'(if_b.anode), 32'hF);
      check("rst_b_seg", 32'(if_b.sevenSegment), 32'hFF);

      // 1234 scan order
      rst = 1'b0;
      @(negedge clk);
      check_a("d0_1234", 4'b0001, 8'h66);
      repeat (4) @(negedge clk);
      check_a("d1_1234", 4'b0010, 8'h4F);
      repeat (4) @(negedge clk);
      check_a("d2_1234", 4'b0100, 8'h5B);
      repeat (4) @(negedge clk);
      check_a("d3_1234", 4'b1000, 8'h06);
      repeat (4) @(negedge clk);
      check_a("wrap_1234", 4'b0001, 8'h66);

      // Leading-zero blanking on 0050
      set_inputs(1'b1, 16'h0050, 4'b0000, 1'b1);
      restart();
      check_a("lz_d0", 4'b0001, 8'h3F);
      repeat (4) @(negedge clk);
      check_a("lz_d1", 4'b0010, 8'h6D);
      repeat (4) @(negedge clk);
      check_a("lz_d2", 4'b0100, 8'h00);
      repeat (4) @(negedge clk);
      check_a("lz_d3", 4'b1000, 8'h00);
      blank_lz = 1'b0;
      @(negedge clk);
      check_a("nolz_d3", 4'b1000, 8'h3F);

      // Decimal point survives blanking
      set_inputs(1'b1, 16'h0000, 4'b0100, 1'b1);
      restart();
      check_a("dp_d0", 4'b0001, 8'h3F);
      repeat (4) @(negedge clk);
      check_a("dp_d1", 4'b0010, 8'h00);
      repeat (4) @(negedge clk);
      check_a("dp_d2", 4'b0100, 8'h80);

      // Inverted polarity instance, digit 0 = F
      set_inputs(1'b1, 16'h000F, 4'b0000, 1'b0);
      restart();
      check("inv_d0_anode", 32'(if_b.anode), 32'hE);
      check("inv_d0_seg", 32'(if_b.sevenSegment), 32'h8E);

      // Enable dropped mid-slot for 10 cycles
      set_inputs(1'b1, 16'h1234, 4'b0000, 1'b0);
      restart();
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check_a("en_off", 4'b0000, 8'h66);
      repeat (9) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      // 12 post-reset edges seen -> slot 3
      check_a("en_back", 4'b1000, 8'h06);

      // Reset while index=2, counter=2
      restart();
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_a("midrst", 4'b0000, 8'h00);
      check("midrst_idx", 32'(if_a.digit_idx), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_a("midrst_d0_first", 4'b0001, 8'h66);
      repeat (3) @(negedge clk);
      check_a("midrst_d0_last", 4'b0001, 8'h66);
      @(negedge clk);
      check_a("midrst_d1", 4'b0010, 8'h4F);

      // Randomized traffic, scoreboard checks every cycle
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 4))
               0: value = 16'h0000;
               1: value = 16'($urandom_range(0, 15));
               2: value = 16'($urandom_range(0, 255));
               3: value = 16'($urandom_range(0, 4095));
               default: value = 16'($urandom_range(0, 65535));
            endcase
            dp = 4'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 9) == 0) en = ~en;
         rst = ($urandom_range(0, 149) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
